// File: rtl/cmb_vector_driver.sv
// cmb_vector_driver: loads a vector serially, applies it atomically, waits, captures the response and returns it serially.
module cmb_vector_driver #(
    parameter int VEC_W  = 16,
    parameter int RSP_W  = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic             sin_valid_pad,
    input  logic             sin_data_pad,
    output logic             sin_ready_pad,
    output logic [VEC_W-1:0] vec_pad,
    input  logic [RSP_W-1:0] rsp_pad,
    output logic             sout_valid_pad,
    output logic             sout_data_pad,
    input  logic             sout_ready_pad,
    output logic             busy_pad,
    output logic [CNT_W-1:0] vec_count_pad
);
    localparam int IW = (VEC_W > 1) ? $clog2(VEC_W) : 1;
    localparam int OW = (RSP_W > 1) ? $clog2(RSP_W) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IN_LAST  = IW'(VEC_W - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(RSP_W - 1);
    localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_SEND} state_t;
    state_t           r_state;
    logic [VEC_W-1:0] r_sh;
    logic [VEC_W-1:0] r_vec;
    logic [RSP_W-1:0] r_rsp;
    logic [IW-1:0]    r_in_cnt;
    logic [OW-1:0]    r_out_cnt;
    logic [SW-1:0]    r_set_cnt;
    logic [CNT_W-1:0] r_vec_cnt;
    logic             r_sin_ready;
    logic             r_sout_valid;
    logic             r_busy;
    logic [VEC_W-1:0] w_sh_next;
    logic             w_sin_acc;
    logic             w_sout_acc;
    assign w_sh_next  = {r_sh[VEC_W-2:0], sin_data_pad};
    assign w_sin_acc  = sin_valid_pad & r_sin_ready & (r_state == S_LOAD);
    assign w_sout_acc = r_sout_valid & sout_ready_pad;
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            r_state      <= S_LOAD;
            r_sh         <= '0;
            r_vec        <= '0;
            r_rsp        <= '0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_set_cnt    <= '0;
            r_vec_cnt    <= '0;
            r_sin_ready  <= 1'b1;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: if (w_sin_acc) begin
                    r_sh     <= w_sh_next;
                    r_in_cnt <= r_in_cnt + IW'(1);
                    if (r_in_cnt == IN_LAST) begin
                        r_vec       <= w_sh_next;
                        r_in_cnt    <= '0;
                        r_set_cnt   <= '0;
                        r_sin_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_set_cnt <= r_set_cnt + SW'(1);
                    if (r_set_cnt == SET_LAST) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rsp        <= rsp_pad;
                    r_sout_valid <= 1'b1;
                    r_state      <= S_SEND;
                end
                default: if (w_sout_acc) begin
                    r_rsp     <= {r_rsp[RSP_W-2:0], 1'b0};
                    r_out_cnt <= r_out_cnt + OW'(1);
                    if (r_out_cnt == OUT_LAST) begin
                        r_out_cnt    <= '0;
                        r_vec_cnt    <= r_vec_cnt + CNT_W'(1);
                        r_sout_valid <= 1'b0;
                        r_sin_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_LOAD;
                    end
                end
            endcase
        end
    end
    assign sin_ready_pad  = r_sin_ready;
    assign vec_pad        = r_vec;
    assign sout_valid_pad = r_sout_valid;
    assign sout_data_pad  = r_rsp[RSP_W-1];
    assign busy_pad       = r_busy;
    assign vec_count_pad  = r_vec_cnt;
endmodule

// File: tb/tb_cmb_vector_driver.sv
// tb_cmb_vector_driver: directed vectors for the serial vector driver, with SETTLE=0/5 and counter-wrap variants.
module tb_cmb_vector_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sin_valid = 1'b0, sin_data = 1'b0, sout_ready = 1'b0;
    logic        sin_ready, sout_valid, sout_data, busy;
    logic [15:0] vec, vec_count;
    logic [3:0]  rsp;
    logic        a_valid = 1'b0, a_data = 1'b0;
    logic        sr0, sv0, sd0, b0, sr5, sv5, sd5, b5;
    logic [15:0] vec0, vec5, cnt5;
    logic [1:0]  cnt0;
    logic [3:0]  rsp0, rsp5;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the benchmark netlist: q=&hi, r=&lo, s=~|hi, t=~|lo
    function automatic logic [3:0] f(input logic [15:0] v);
        return {&v[15:8], &v[7:0], ~|v[15:8], ~|v[7:0]};
    endfunction

    assign rsp = f(vec);

    cmb_vector_driver u_dut (
        .clk_pad(clk), .rst_pad(rst), .sin_valid_pad(sin_valid), .sin_data_pad(sin_data),
        .sin_ready_pad(sin_ready), .vec_pad(vec), .rsp_pad(rsp), .sout_valid_pad(sout_valid),
        .sout_data_pad(sout_data), .sout_ready_pad(sout_ready), .busy_pad(busy),
        .vec_count_pad(vec_count));

    cmb_vector_driver #(.SETTLE(0), .CNT_W(2)) u_s0 (
        .clk_pad(clk), .rst_pad(rst), .sin_valid_pad(a_valid), .sin_data_pad(a_data),
        .sin_ready_pad(sr0), .vec_pad(vec0), .rsp_pad(rsp0), .sout_valid_pad(sv0),
        .sout_data_pad(sd0), .sout_ready_pad(1'b1), .busy_pad(b0), .vec_count_pad(cnt0));

    cmb_vector_driver #(.SETTLE(5)) u_s5 (
        .clk_pad(clk), .rst_pad(rst), .sin_valid_pad(a_valid), .sin_data_pad(a_data),
        .sin_ready_pad(sr5), .vec_pad(vec5), .rsp_pad(rsp5), .sout_valid_pad(sv5),
        .sout_data_pad(sd5), .sout_ready_pad(1'b1), .busy_pad(b5), .vec_count_pad(cnt5));

    // Slow netlist models: output follows input three clock cycles later
    logic [3:0] d0_1 = '0, d0_2 = '0, d0_3 = '0, d5_1 = '0, d5_2 = '0, d5_3 = '0;
    always @(posedge clk) begin
        d0_1 <= f(vec0); d0_2 <= d0_1; d0_3 <= d0_2;
        d5_1 <= f(vec5); d5_2 <= d5_1; d5_3 <= d5_2;
    end
    assign rsp0 = d0_3;
    assign rsp5 = d5_3;

    // Measures vec update to first serial-out cycle and collects returned bits
    int         cyc = 0, tv0 = 0, tv5 = 0, lat0 = 0, lat5 = 0;
    logic [15:0] pv0 = '0, pv5 = '0;
    logic        psv0 = 1'b0, psv5 = 1'b0;
    logic [3:0]  rs0 = '0, rs5 = '0;
    always @(negedge clk) begin
        cyc  <= cyc + 1;
        pv0  <= vec0; pv5 <= vec5;
        psv0 <= sv0;  psv5 <= sv5;
        if (vec0 != pv0) tv0 <= cyc;
        if (vec5 != pv5) tv5 <= cyc;
        if (sv0 && !psv0) lat0 <= cyc - tv0;
        if (sv5 && !psv5) lat5 <= cyc - tv5;
        if (sv0) rs0 <= {rs0[2:0], sd0};
        if (sv5) rs5 <= {rs5[2:0], sd5};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_vec(input logic [15:0] v, input int gap);
        logic [15:0] pv;
        pv = vec;
        for (int i = 15; i >= 0; i--) begin
            repeat (gap) begin @(negedge clk); sin_valid = 1'b0; end
            @(negedge clk);
            if (i != 15) chk("vec_no_partial", vec, pv);
            sin_valid = 1'b1;
            sin_data  = v[i];
        end
        @(negedge clk);
        sin_valid = 1'b0;
        chk("vec_apply", vec, v);
        chk("busy_after_load", busy, 1);
        chk("sin_ready_after_load", sin_ready, 0);
    endtask

    task automatic recv(input logic [7:0] pat, input int plen, input logic hold, output logic [3:0] r);
        int   bits, k, n;
        logic stalled, pd, rdy;
        bits = 0; k = 0; n = 0; stalled = 1'b0; pd = 1'b0; r = '0;
        while (bits < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (hold) begin sin_valid = 1'b1; sin_data = 1'b1; end
            if (sout_valid) begin
                if (stalled) chk("sout_data_stable", sout_data, pd);
                chk("sin_ready_in_send", sin_ready, 0);
                chk("busy_in_send", busy, 1);
                rdy = (k < plen) ? pat[plen-1-k] : 1'b1;
                k++;
                sout_ready = rdy;
                if (rdy) begin r = {r[2:0], sout_data}; bits++; stalled = 1'b0; end
                else begin stalled = 1'b1; pd = sout_data; end
            end else sout_ready = 1'b0;
        end
        chk("recv_bits", bits, 4);
        @(negedge clk);
        sin_valid = 1'b0; sout_ready = 1'b0;
        chk("sin_ready_after_send", sin_ready, 1);
        chk("sout_valid_after_send", sout_valid, 0);
        chk("busy_after_send", busy, 0);
    endtask

    task automatic aux_vec(input logic [15:0] v, input logic [3:0] e0, input logic [3:0] e5, input logic [1:0] ec0);
        int n;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk); a_valid = 1'b1; a_data = v[i];
        end
        @(negedge clk); a_valid = 1'b0;
        n = 0;
        while ((b0 || b5) && n < 100) begin @(negedge clk); n++; end
        chk("aux_done", n < 100, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk("s0_latency", lat0, 1);
        chk("s5_latency", lat5, 6);
        chk("s0_rsp", rs0, e0);
        chk("s5_rsp", rs5, e5);
        chk("s0_count_wrap", cnt0, ec0);
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  r;
        logic [7:0]  pat;
        int          plen;
        logic        hold;
        logic [15:0] cnt;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[5];
        logic [3:0]  got;
        tbl[0] = '{16'hFFFF, 4'hC, 8'h00, 0, 1'b0, 16'd1};
        tbl[1] = '{16'h0000, 4'h3, 8'h00, 0, 1'b0, 16'd2};
        tbl[2] = '{16'hFFFF, 4'hC, 8'h4B, 7, 1'b0, 16'd3};
        tbl[3] = '{16'h00FF, 4'h6, 8'h00, 0, 1'b1, 16'd4};
        tbl[4] = '{16'hFF00, 4'h9, 8'h00, 0, 1'b0, 16'd5};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_vec", vec, 0);
        chk("rst_sin_ready", sin_ready, 1);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_sout_data", sout_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", vec_count, 0);
        for (int t = 0; t < 5; t++) begin
            send_vec(tbl[t].v, 0);
            recv(tbl[t].pat, tbl[t].plen, tbl[t].hold, got);
            chk("rsp", got, tbl[t].r);
            chk("vec_count", vec_count, tbl[t].cnt);
            chk("vec_hold", vec, tbl[t].v);
        end
        // Partial gapped vector, then reset discards it
        for (int i = 15; i >= 6; i--) begin
            repeat (2) begin @(negedge clk); sin_valid = 1'b0; end
            @(negedge clk); sin_valid = 1'b1; sin_data = i[0];
        end
        @(negedge clk); sin_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_vec", vec, 0);
        chk("midrst_sin_ready", sin_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", vec_count, 0);
        send_vec(16'hA5C3, 0);
        recv(8'h00, 0, 1'b0, got);
        chk("rsp_a5c3", got, 4'h0);
        chk("count_a5c3", vec_count, 1);
        // SETTLE=0 samples before the slow model updates, SETTLE=5 after
        aux_vec(16'hFFFF, 4'h3, 4'hC, 2'd1);
        aux_vec(16'h0000, 4'hC, 4'h3, 2'd2);
        aux_vec(16'hFFFF, 4'h3, 4'hC, 2'd3);
        aux_vec(16'h0000, 4'hC, 4'h3, 2'd0);
        chk("s5_count", cnt5, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
